// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - shared RV32 decode constants and queue entry types
package decode_queue_pkg;

    localparam int OPENUM_W = 6;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OPC_ARITH     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [OPENUM_W-1:0] OP_NOP    = 6'd0;
    localparam logic [OPENUM_W-1:0] OP_LUI    = 6'd1;
    localparam logic [OPENUM_W-1:0] OP_AUIPC  = 6'd2;
    localparam logic [OPENUM_W-1:0] OP_JAL    = 6'd3;
    localparam logic [OPENUM_W-1:0] OP_JALR   = 6'd4;
    localparam logic [OPENUM_W-1:0] OP_BEQ    = 6'd5;
    localparam logic [OPENUM_W-1:0] OP_BNE    = 6'd6;
    localparam logic [OPENUM_W-1:0] OP_BLT    = 6'd7;
    localparam logic [OPENUM_W-1:0] OP_BGE    = 6'd8;
    localparam logic [OPENUM_W-1:0] OP_BLTU   = 6'd9;
    localparam logic [OPENUM_W-1:0] OP_BGEU   = 6'd10;
    localparam logic [OPENUM_W-1:0] OP_LB     = 6'd11;
    localparam logic [OPENUM_W-1:0] OP_LH     = 6'd12;
    localparam logic [OPENUM_W-1:0] OP_LW     = 6'd13;
    localparam logic [OPENUM_W-1:0] OP_LBU    = 6'd14;
    localparam logic [OPENUM_W-1:0] OP_LHU    = 6'd15;
    localparam logic [OPENUM_W-1:0] OP_SB     = 6'd16;
    localparam logic [OPENUM_W-1:0] OP_SH     = 6'd17;
    localparam logic [OPENUM_W-1:0] OP_SW     = 6'd18;
    localparam logic [OPENUM_W-1:0] OP_ADDI   = 6'd19;
    localparam logic [OPENUM_W-1:0] OP_SLTI   = 6'd20;
    localparam logic [OPENUM_W-1:0] OP_SLTIU  = 6'd21;
    localparam logic [OPENUM_W-1:0] OP_XORI   = 6'd22;
    localparam logic [OPENUM_W-1:0] OP_ORI    = 6'd23;
    localparam logic [OPENUM_W-1:0] OP_ANDI   = 6'd24;
    localparam logic [OPENUM_W-1:0] OP_SLLI   = 6'd25;
    localparam logic [OPENUM_W-1:0] OP_SRLI   = 6'd26;
    localparam logic [OPENUM_W-1:0] OP_SRAI   = 6'd27;
    localparam logic [OPENUM_W-1:0] OP_ADD    = 6'd28;
    localparam logic [OPENUM_W-1:0] OP_SUB    = 6'd29;
    localparam logic [OPENUM_W-1:0] OP_SLL    = 6'd30;
    localparam logic [OPENUM_W-1:0] OP_SLT    = 6'd31;
    localparam logic [OPENUM_W-1:0] OP_SLTU   = 6'd32;
    localparam logic [OPENUM_W-1:0] OP_XOR    = 6'd33;
    localparam logic [OPENUM_W-1:0] OP_SRL    = 6'd34;
    localparam logic [OPENUM_W-1:0] OP_SRA    = 6'd35;
    localparam logic [OPENUM_W-1:0] OP_OR     = 6'd36;
    localparam logic [OPENUM_W-1:0] OP_AND    = 6'd37;
    localparam logic [OPENUM_W-1:0] OP_MUL    = 6'd38;
    localparam logic [OPENUM_W-1:0] OP_MULH   = 6'd39;
    localparam logic [OPENUM_W-1:0] OP_MULHSU = 6'd40;
    localparam logic [OPENUM_W-1:0] OP_MULHU  = 6'd41;
    localparam logic [OPENUM_W-1:0] OP_DIV    = 6'd42;
    localparam logic [OPENUM_W-1:0] OP_DIVU   = 6'd43;
    localparam logic [OPENUM_W-1:0] OP_REM    = 6'd44;
    localparam logic [OPENUM_W-1:0] OP_REMU   = 6'd45;

    typedef struct packed {
        logic [31:0]         pc;
        logic [OPENUM_W-1:0] openum;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic                is_jump;
        logic                is_store;
        logic                illegal;
    } entry_t;

endpackage

// File: rtl/decode_core.sv
// rtl/decode_core.sv - combinational RV32I (+optional RV32M) instruction decoder
module decode_core
    import decode_queue_pkg::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [31:0]         inst,
    output logic [OPENUM_W-1:0] openum,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [31:0]         imm,
    output logic                is_jump,
    output logic                is_store,
    output logic                illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    // Classify by opcode/funct fields; any illegal encoding collapses to a NOP with no side effects
    always_comb begin
        openum   = OP_NOP;
        rd       = inst[11:7];
        imm      = 32'd0;
        is_jump  = 1'b0;
        is_store = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                openum = OP_LUI;
                imm    = {inst[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                openum = OP_AUIPC;
                imm    = {inst[31:12], 12'd0};
            end
            OPC_JAL: begin
                openum  = OP_JAL;
                is_jump = 1'b1;
                imm     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                openum  = OP_JALR;
                is_jump = 1'b1;
                imm     = {{20{inst[31]}}, inst[31:20]};
                illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                rd      = 5'd0;
                is_jump = 1'b1;
                imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                case (f3)
                    3'b000:  openum = OP_BEQ;
                    3'b001:  openum = OP_BNE;
                    3'b100:  openum = OP_BLT;
                    3'b101:  openum = OP_BGE;
                    3'b110:  openum = OP_BLTU;
                    3'b111:  openum = OP_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                imm = {{20{inst[31]}}, inst[31:20]};
                case (f3)
                    3'b000:  openum = OP_LB;
                    3'b001:  openum = OP_LH;
                    3'b010:  openum = OP_LW;
                    3'b100:  openum = OP_LBU;
                    3'b101:  openum = OP_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                rd       = 5'd0;
                is_store = 1'b1;
                imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                case (f3)
                    3'b000:  openum = OP_SB;
                    3'b001:  openum = OP_SH;
                    3'b010:  openum = OP_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_ARITH_IMM: begin
                imm = {{20{inst[31]}}, inst[31:20]};
                case (f3)
                    F3_ADD_SUB: openum = OP_ADDI;
                    F3_SLT:     openum = OP_SLTI;
                    F3_SLTU:    openum = OP_SLTIU;
                    F3_XOR:     openum = OP_XORI;
                    F3_OR:      openum = OP_ORI;
                    F3_AND:     openum = OP_ANDI;
                    F3_SLL: begin
                        imm     = {27'd0, inst[24:20]};
                        openum  = OP_SLLI;
                        illegal = (f7 != F7_ZERO);
                    end
                    default: begin
                        imm = {27'd0, inst[24:20]};
                        if (f7 == F7_ZERO)
                            openum = OP_SRLI;
                        else if (f7 == F7_ALT)
                            openum = OP_SRAI;
                        else
                            illegal = 1'b1;
                    end
                endcase
            end
            OPC_ARITH: begin
                if (f7 == F7_ZERO) begin
                    case (f3)
                        F3_ADD_SUB: openum = OP_ADD;
                        F3_SLL:     openum = OP_SLL;
                        F3_SLT:     openum = OP_SLT;
                        F3_SLTU:    openum = OP_SLTU;
                        F3_XOR:     openum = OP_XOR;
                        F3_SRL_SRA: openum = OP_SRL;
                        F3_OR:      openum = OP_OR;
                        default:    openum = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        F3_ADD_SUB: openum = OP_SUB;
                        F3_SRL_SRA: openum = OP_SRA;
                        default:    illegal = 1'b1;
                    endcase
                end else if (f7 == F7_MULDIV && ENABLE_M != 0) begin
                    case (f3)
                        3'b000:  openum = OP_MUL;
                        3'b001:  openum = OP_MULH;
                        3'b010:  openum = OP_MULHSU;
                        3'b011:  openum = OP_MULHU;
                        3'b100:  openum = OP_DIV;
                        3'b101:  openum = OP_DIVU;
                        3'b110:  openum = OP_REM;
                        default: openum = OP_REMU;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                illegal = (f3 != 3'b000);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            openum   = OP_NOP;
            is_jump  = 1'b0;
            is_store = 1'b0;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decode-on-push FIFO between fetch and dispatch
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 0
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       in_valid,
    input  logic [31:0]                in_inst,
    input  logic [31:0]                in_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPENUM_W-1:0]        out_openum,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [31:0]                out_imm,
    output logic [31:0]                out_pc,
    output logic                       out_is_jump,
    output logic                       out_is_store,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

    entry_t        slots [DEPTH];
    entry_t        new_entry;
    entry_t        head_entry;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;

    decode_core #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .inst     (in_inst),
        .openum   (new_entry.openum),
        .rd       (new_entry.rd),
        .rs1      (new_entry.rs1),
        .rs2      (new_entry.rs2),
        .imm      (new_entry.imm),
        .is_jump  (new_entry.is_jump),
        .is_store (new_entry.is_store),
        .illegal  (new_entry.illegal)
    );
    assign new_entry.pc = in_pc;

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && rdy_in && !flush_in;
    assign pop       = out_valid && out_ready && rdy_in && !flush_in;

    assign head_entry   = slots[head];
    assign out_openum   = head_entry.openum;
    assign out_rd       = head_entry.rd;
    assign out_rs1      = head_entry.rs1;
    assign out_rs2      = head_entry.rs2;
    assign out_imm      = head_entry.imm;
    assign out_pc       = head_entry.pc;
    assign out_is_jump  = head_entry.is_jump;
    assign out_is_store = head_entry.is_store;
    assign out_illegal  = head_entry.illegal;

    // Slot storage is never reset; a push in a reset cycle lands but is unreachable
    always_ff @(posedge clk_in) begin
        if (push) begin
            slots[tail] <= new_entry;
        end
    end

    // Pointer and occupancy bookkeeping; reset beats flush, flush beats push/pop
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + AW'(1);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard bench for decode_queue with and without RV32M
module tb_decode_queue;
    import decode_queue_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [5:0]  op0;
        logic [5:0]  op1;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        jump;
        logic        store;
        logic        ill0;
        logic        ill1;
        logic [3:0]  fmask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    exp_t        cur;

    logic        in_ready0, out_valid0, jump0, store0, ill0;
    logic [5:0]  op0;
    logic [4:0]  rd0, rs1_0, rs2_0;
    logic [31:0] imm0, pc0;
    logic [2:0]  count0;
    logic        in_ready1, out_valid1, jump1, store1, ill1;
    logic [5:0]  op1;
    logic [4:0]  rd1, rs1_1, rs2_1;
    logic [31:0] imm1, pc1;
    logic [2:0]  count1;

    exp_t        tbl[$];
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .ENABLE_M(0)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .in_valid(in_valid), .in_inst(cur.inst), .in_pc(cur.pc), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_openum(op0), .out_rd(rd0), .out_rs1(rs1_0), .out_rs2(rs2_0),
        .out_imm(imm0), .out_pc(pc0), .out_is_jump(jump0), .out_is_store(store0),
        .out_illegal(ill0), .count(count0)
    );

    decode_queue #(.DEPTH(4), .ENABLE_M(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .in_valid(in_valid), .in_inst(cur.inst), .in_pc(cur.pc), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_openum(op1), .out_rd(rd1), .out_rs1(rs1_1), .out_rs2(rs2_1),
        .out_imm(imm1), .out_pc(pc1), .out_is_jump(jump1), .out_is_store(store1),
        .out_illegal(ill1), .count(count1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // fmask bits: 0=rd 1=rs1 2=rs2 3=imm are meaningful for this format
    function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [5:0] o0, input logic [5:0] o1,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic j, input logic s,
                                input logic i0, input logic i1, input logic [3:0] fm);
        exp_t e;
        e.id = tbl.size(); e.inst = inst; e.pc = pc; e.op0 = o0; e.op1 = o1;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.jump = j; e.store = s;
        e.ill0 = i0; e.ill1 = i1; e.fmask = fm;
        return e;
    endfunction

    task automatic check_fields(input string p, input exp_t e, input logic [5:0] op, input logic il,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic j, input logic s,
                                input logic [5:0] eop, input logic eil);
        chk($sformatf("%s%0d_op", p, e.id), 32'(op), 32'(eop));
        chk($sformatf("%s%0d_illegal", p, e.id), 32'(il), 32'(eil));
        if (!eil) begin
            chk($sformatf("%s%0d_jump", p, e.id), 32'(j), 32'(e.jump));
            chk($sformatf("%s%0d_store", p, e.id), 32'(s), 32'(e.store));
            if (e.fmask[0]) chk($sformatf("%s%0d_rd", p, e.id), 32'(rd), 32'(e.rd));
            if (e.fmask[1]) chk($sformatf("%s%0d_rs1", p, e.id), 32'(rs1), 32'(e.rs1));
            if (e.fmask[2]) chk($sformatf("%s%0d_rs2", p, e.id), 32'(rs2), 32'(e.rs2));
            if (e.fmask[3]) chk($sformatf("%s%0d_imm", p, e.id), imm, e.imm);
        end
    endtask

    // Inputs are set in the low phase; sample #1 later, update the model, then cross one edge
    task automatic step();
        bit pushing, popping;
        exp_t e;
        #1;
        chk("count", 32'(count0), 32'(sb.size()));
        chk("count_m", 32'(count1), 32'(sb.size()));
        chk("out_valid", 32'(out_valid0), 32'(sb.size() != 0));
        chk("in_ready", 32'(in_ready0), 32'(sb.size() < 4));
        if (rst) begin
            sb.delete();
        end else if (rdy) begin
            if (flush) begin
                sb.delete();
            end else begin
                pushing = in_valid && (sb.size() < 4);
                popping = out_ready && (sb.size() != 0);
                if (popping) begin
                    e = sb.pop_front();
                    chk($sformatf("e%0d_pc", e.id), pc0, e.pc);
                    chk($sformatf("m%0d_pc", e.id), pc1, e.pc);
                    check_fields("e", e, op0, ill0, rd0, rs1_0, rs2_0, imm0, jump0, store0, e.op0, e.ill0);
                    check_fields("m", e, op1, ill1, rd1, rs1_1, rs2_1, imm1, jump1, store1, e.op1, e.ill1);
                end
                if (pushing) sb.push_back(cur);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        step();
        chk("drained_count", 32'(count0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(mk(32'h00500093, 32'h100, OP_ADDI, OP_ADDI, 1, 0, 0, 32'd5, 0, 0, 0, 0, 4'b1011));
        tbl.push_back(mk(32'h40335293, 32'h104, OP_SRAI, OP_SRAI, 5, 6, 0, 32'd3, 0, 0, 0, 0, 4'b1011));
        tbl.push_back(mk(32'h022081B3, 32'h108, OP_NOP, OP_MUL, 3, 1, 2, 32'd0, 0, 0, 1, 0, 4'b0111));
        tbl.push_back(mk(32'hFFFFFFFF, 32'h10C, OP_NOP, OP_NOP, 0, 0, 0, 32'd0, 0, 0, 1, 1, 4'b0000));
        tbl.push_back(mk(32'h008000EF, 32'h110, OP_JAL, OP_JAL, 1, 0, 0, 32'd8, 1, 0, 0, 0, 4'b1001));
        tbl.push_back(mk(32'hFE208EE3, 32'h114, OP_BEQ, OP_BEQ, 0, 1, 2, 32'hFFFFFFFC, 1, 0, 0, 0, 4'b1111));
        tbl.push_back(mk(32'hFE20AC23, 32'h118, OP_SW, OP_SW, 0, 1, 2, 32'hFFFFFFF8, 0, 1, 0, 0, 4'b1111));
        tbl.push_back(mk(32'h123452B7, 32'h11C, OP_LUI, OP_LUI, 5, 0, 0, 32'h12345000, 0, 0, 0, 0, 4'b1001));
        tbl.push_back(mk(32'h402081B3, 32'h120, OP_SUB, OP_SUB, 3, 1, 2, 32'd0, 0, 0, 0, 0, 4'b0111));
        tbl.push_back(mk(32'h02335293, 32'h124, OP_NOP, OP_NOP, 0, 0, 0, 32'd0, 0, 0, 1, 1, 4'b0000));
        tbl.push_back(mk(32'h402091B3, 32'h128, OP_NOP, OP_NOP, 0, 0, 0, 32'd0, 0, 0, 1, 1, 4'b0000));
        tbl.push_back(mk(32'h00000073, 32'h12C, OP_NOP, OP_NOP, 0, 0, 0, 32'd0, 0, 0, 1, 1, 4'b0000));
        tbl.push_back(mk(32'h0FF0000F, 32'h130, OP_NOP, OP_NOP, 0, 0, 0, 32'd0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(32'h0040A183, 32'h134, OP_LW, OP_LW, 3, 1, 0, 32'd4, 0, 0, 0, 0, 4'b1011));
        tbl.push_back(mk(32'h0220D1B3, 32'h138, OP_NOP, OP_DIVU, 3, 1, 2, 32'd0, 0, 0, 1, 0, 4'b0111));
        tbl.push_back(mk(32'hFE20AEE3, 32'h13C, OP_NOP, OP_NOP, 0, 0, 0, 32'd0, 0, 0, 1, 1, 4'b0000));
        tbl.push_back(mk(32'hFFF08093, 32'h140, OP_ADDI, OP_ADDI, 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 4'b1011));
        tbl.push_back(mk(32'h00008067, 32'h144, OP_JALR, OP_JALR, 0, 1, 0, 32'd0, 1, 0, 0, 0, 4'b1011));

        // Reset with a push pending: the push must be lost
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; cur = tbl[0];
        @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0; in_valid = 1'b0;
        step();

        // Streaming: every decode class, push and pop overlapping
        foreach (tbl[i]) begin
            cur = tbl[i]; in_valid = 1'b1;
            step();
        end
        drain();

        // Fill to DEPTH with a fifth request held, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cur = tbl[i]; in_valid = 1'b1;
            step();
        end
        step();
        out_ready = 1'b1;
        step();
        drain();

        // Flush a full queue while a push is offered
        out_ready = 1'b0;
        for (int i = 5; i < 9; i++) begin
            cur = tbl[i]; in_valid = 1'b1;
            step();
        end
        flush = 1'b1; cur = tbl[9];
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        cur = tbl[10]; in_valid = 1'b1; out_ready = 1'b1;
        step();
        drain();

        // Stall: rdy low must freeze everything, including a pending pop and push
        out_ready = 1'b0; cur = tbl[13]; in_valid = 1'b1;
        step();
        rdy = 1'b0; out_ready = 1'b1; cur = tbl[3];
        for (int i = 0; i < 3; i++) step();
        rdy = 1'b1;
        step();
        drain();

        // Reset mid-operation discards queued entries and the same-cycle push
        out_ready = 1'b0;
        for (int i = 14; i < 17; i++) begin
            cur = tbl[i]; in_valid = 1'b1;
            step();
        end
        rst = 1'b1; cur = tbl[0];
        step();
        rst = 1'b0; in_valid = 1'b0;
        step();
        cur = tbl[17]; in_valid = 1'b1;
        step();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of decoded-entry slots; power of two, at least 2.
REQ-002 SHALL have parameter ENABLE_M, default 0: 1 enables RV32M decode, 0 makes RV32M encodings illegal.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rdy_in, input, 1 bit: global enable; low freezes all state.
REQ-006 SHALL have port flush_in, input, 1 bit: discards all queued entries (mispredict).
REQ-007 SHALL have ports in_valid (input, 1), in_inst (input, 32), in_pc (input, 32) and in_ready (output, 1): fetch-side handshake.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): dispatch-side handshake.
REQ-009 SHALL have outputs out_openum (OPENUM width), out_rd, out_rs1 and out_rs2 (5 each), out_imm (32) and out_pc (32).
REQ-010 SHALL have outputs out_is_jump (1), out_is_store (1) and out_illegal (1).
REQ-011 SHALL have output count, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-012 Push SHALL occur when in_valid && in_ready && rdy_in && !flush_in; the instruction is decoded combinationally and written to the tail slot.
REQ-013 Pop SHALL occur when out_valid && out_ready && rdy_in && !flush_in; the head pointer advances.
REQ-014 in_ready SHALL equal (count < DEPTH); no full-queue bypass.
REQ-015 out_valid SHALL equal (count != 0); out_* fields SHALL be driven from the head slot.
REQ-016 Latency: an entry pushed in cycle N SHALL appear at the outputs in cycle N+1 at the earliest.
REQ-017 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-018 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-019 flush_in with rdy_in high SHALL zero count and both pointers next cycle, and SHALL override a same-cycle push or pop.
REQ-020 rdy_in low SHALL hold all registers; outputs remain combinational from the held state.
REQ-021 Decode (RV32I): U, J, I, B, S and R formats SHALL produce the standard sign-extended immediates.
REQ-022 Decode: rd SHALL be forced to 0 for B-type and S-type.
REQ-023 Decode: is_jump SHALL be 1 for JAL, JALR and branches; is_store SHALL be 1 for SB, SH and SW.
REQ-024 Decode: for SLLI, SRLI and SRAI, imm SHALL be the zero-extended shamt inst[24:20].
REQ-025 Decode: illegal=1 and openum=NOP SHALL result from any of: unknown opcode; undefined funct3; funct7 not in {0000000, 0100000} for R-type or shift-immediate; 0100000 used with a funct3 that does not permit it; SYSTEM opcode.
REQ-026 Decode: with ENABLE_M=1, OPCODE_ARITH with funct7=0000001 SHALL decode to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU by funct3.
REQ-027 Decode: with ENABLE_M=0, the encodings in REQ-026 SHALL be illegal.
REQ-028 Decode: FENCE SHALL decode to NOP with illegal=0.
REQ-029 Illegal entries SHALL still be queued, preserving order for precise exceptions.

Reset
REQ-030 rst_in high at a rising edge SHALL set count, head and tail to 0, regardless of rdy_in and flush_in.
REQ-031 After reset: out_valid=0, in_ready=1, count=0.
REQ-032 Slot contents need not reset; out_* data fields are don't-care while out_valid=0.
REQ-033 Reset mid-operation SHALL discard all entries; a push in the reset cycle is lost.

Structure
REQ-034 The shared definitions package SHALL hold opcode, funct3 and funct7 constants and all OPENUM codes, including new MUL..REMU codes and an OPENUM width constant.
REQ-035 Decoding SHALL be a combinational sub-module decode_core (parameter ENABLE_M, adds illegal output), instantiated once on the push path.
REQ-036 Queue storage SHALL be a register array of DEPTH packed decoded entries.

Verification
REQ-037 Push 0x00500093 (addi x1,x0,5), pc 0x100, out_ready=1 -> next cycle out_valid=1, ADDI, rd=1, rs1=0, imm=5, out_pc=0x100, illegal=0.
REQ-038 Push 0x40335293 -> SRAI, rd=5, rs1=6, imm=3.
REQ-039 Push 0x022081B3 -> ENABLE_M=0: illegal=1, NOP; ENABLE_M=1: MUL, rd=3, rs1=1, rs2=2.
REQ-040 DEPTH=4, out_ready=0, push 5 -> in_ready=0 after the 4th push, count=4; the 5th is held; drain returns entries in order.
REQ-041 Full queue with flush_in=1 and in_valid=1 -> next cycle count=0, out_valid=0; the flushed push is not stored.
REQ-042 Push 0xFFFFFFFF while rdy_in=0 for 3 cycles -> no state change; after rdy_in=1 the entry appears with illegal=1.
